// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: default sizes,
// FSM state encoding and a one-hot to index helper.
package rr_arb_pkg;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 3;
  localparam int N_MAX     = 32;
  localparam int IDX_W_MAX = 5;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // OR of the indices of all set bits; exact for a one-hot (or zero) input.
  function automatic logic [IDX_W_MAX-1:0] onehot_to_idx(input logic [N_MAX-1:0] oh);
    logic [IDX_W_MAX-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MAX; i++)
      if (oh[i]) idx = idx | IDX_W_MAX'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: scans candidates from index ptr upward, wrapping
// at N-1, and returns the first set bit as one-hot plus its index.
module rr_pick import rr_arb_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N-1:0]     candidates,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // First set bit at or after ptr; index arithmetic wraps since N = 2**IDX_W.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any && candidates[idx]) begin
        any         = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter feeding the 8-to-3 encoder: sticky request latch,
// one registered one-hot grant at a time, retired by Ready, pointer rotates
// past each retired winner.
// Optional sticky overrun flags are built when RR_ARB_OVERRUN_EN is defined.
module rr_onehot_arbiter import rr_arb_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Req,
  input  logic         Enable,
  input  logic         Ready,
  output logic [N-1:0] Grant,
  output logic         Valid,
  output logic [N-1:0] Pending
`ifdef RR_ARB_OVERRUN_EN
  ,
  input  logic         Overrun_Clr,
  output logic [N-1:0] Overrun
`endif
);

  state_t           state;
  logic [IDX_W-1:0] ptr, gidx, ptr_adv, pick_ptr, win_idx;
  logic [N-1:0]     clear, cand, win;
  logic             any, hs;

  // A grant retires when it is presented (GRANT state) and Ready is high.
  assign hs       = (state == GRANT) && Ready;
  assign clear    = hs ? Grant : '0;
  assign ptr_adv  = gidx + IDX_W'(1);
  // On a handshake the follow-on pick already uses the rotated pointer and
  // excludes the bit being retired; fresh requests only join next edge.
  assign pick_ptr = (state == GRANT) ? ptr_adv : ptr;
  assign cand     = (state == GRANT) ? (Pending & ~Grant) : Pending;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .candidates (cand),
    .ptr        (pick_ptr),
    .winner     (win),
    .winner_idx (win_idx),
    .any        (any)
  );

  // Request latch, grant issue/retire FSM and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      Grant   <= '0;
      Valid   <= 1'b0;
      ptr     <= '0;
      gidx    <= '0;
      Pending <= '0;
    end else begin
      // A request on the retire edge re-arms its bit.
      Pending <= (Pending & ~clear) | Req;
      case (state)
        IDLE: begin
          if (Enable && any) begin
            Grant <= win;
            gidx  <= win_idx;
            Valid <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (Ready) begin
            ptr <= ptr_adv;
            if (Enable && any) begin
              Grant <= win;
              gidx  <= win_idx;
            end else begin
              Grant <= '0;
              Valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RR_ARB_OVERRUN_EN
  // Sticky flag for a request that coalesced into an already-pending bit.
  always_ff @(posedge clk) begin
    if (rst) Overrun <= '0;
    else     Overrun <= (Overrun_Clr ? '0 : Overrun) | (Req & Pending & ~clear);
  end
`endif

endmodule
